// File: rtl/and_32_reg_pkg.sv
// Shared ALU constants for the gate-level AND datapath.
// Width and the result reset value live here so every ALU slice agrees on them.
package and_32_reg_pkg;

   localparam int ALU_WIDTH = 32;

   // Result register reset value.
   localparam logic [ALU_WIDTH-1:0] RESULT_RST = '0;

endpackage

// File: rtl/and_1bit.sv
// Single-bit AND cell; the building block for the bitwise AND core.
module and_1bit (
   input  logic a,
   input  logic b,
   output logic r
);

   assign r = a & b;

endmodule

// File: rtl/and_32_reg.sv
// 32-bit bitwise AND built from one-bit cells, with a single registered output stage
// carrying the result, a valid strobe and a zero flag for the ALU flag logic.
module and_32_reg
   import and_32_reg_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             in_valid,
   output logic [WIDTH-1:0] R,
   output logic             out_valid,
   output logic             zero
);

   logic [WIDTH-1:0] and_bits;
   logic             zero_next;
   logic [WIDTH-1:0] r_reg;
   logic             zero_reg;
   logic             out_valid_reg;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         and_1bit u_and (
            .a(A[gi]),
            .b(B[gi]),
            .r(and_bits[gi])
         );
      end
   endgenerate

   assign zero_next = (and_bits == '0);

   // R and zero only move on a capture, so undriven operands while idle never reach them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_reg         <= WIDTH'(RESULT_RST);
         zero_reg      <= 1'b1;
         out_valid_reg <= 1'b0;
      end else begin
         out_valid_reg <= in_valid;
         if (in_valid) begin
            r_reg    <= and_bits;
            zero_reg <= zero_next;
         end
      end
   end

   assign R         = r_reg;
   assign zero      = zero_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_and_32_reg.sv
// Scoreboard bench for and_32_reg: the driver queues expected results as it issues
// operands, and an independent monitor pops and compares whenever out_valid is seen.
module tb_and_32_reg;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         in_valid;
   logic [W-1:0] r;
   logic         out_valid;
   logic         zero;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_r;
   bit           armed = 1'b0;
   bit           done  = 1'b0;
   int           n_cmp = 0;
   int           n_bad = 0;
   int           n_txn = 0;

   always #5 clk = ~clk;

   and_32_reg #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .A        (a),
      .B        (b),
      .in_valid (in_valid),
      .R        (r),
      .out_valid(out_valid),
      .zero     (zero)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: a valid operand pair yields A & B one cycle later; idle cycles hold.
   task automatic issue(input logic [W-1:0] opa, input logic [W-1:0] opb, input logic [W-1:0] expv);
      @(posedge clk);
      #1;
      a        = opa;
      b        = opb;
      in_valid = 1'b1;
      exp_q.push_back(expv);
   endtask

   task automatic idle(input bit use_x);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (use_x) begin
         a = 'x;
         b = 'x;
      end else begin
         a = $urandom;
         b = $urandom;
      end
   endtask

   task automatic check_reset_now(input string tag);
      check({tag, "_R"}, r, '0);
      check({tag, "_zero"}, W'(zero), W'(1'b1));
      check({tag, "_out_valid"}, W'(out_valid), W'(1'b0));
   endtask

   // Monitor: pops one expectation per out_valid, otherwise checks that R/zero hold.
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (done) break;
         if (!armed) continue;
         if (!rst_n) begin
            check_reset_now("in_reset");
         end else if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_out_valid: got out_valid=1 R=%h, required out_valid=0", r);
            end else begin
               e = exp_q.pop_front();
               n_txn++;
               $display("txn %0d: R=%h zero=%b expected R=%h", n_txn, r, zero, e);
               check("R", r, e);
               check("zero", W'(zero), W'(e == '0));
               last_r = e;
            end
         end else begin
            check("hold_R", r, last_r);
            check("hold_zero", W'(zero), W'(last_r == '0));
         end
      end
   end

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           wait_cnt;

      rst_n    = 1'b1;
      a        = $urandom;
      b        = $urandom;
      in_valid = 1'b1;
      last_r   = '0;

      // Asynchronous reset with no clock edge in between.
      #2 rst_n = 1'b0;
      #1 check_reset_now("async_reset");
      armed = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      repeat (3) idle(1'b0);

      issue(32'hFFFF0000, 32'h0000FFFF, 32'h00000000);
      idle(1'b0);
      idle(1'b0);
      issue(32'hFFFFFFFF, 32'h00000000, 32'h00000000);
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
      issue(32'hAAAAAAAA, 32'hF0F0F0F0, 32'hA0A0A0A0);
      issue(32'h12345678, 32'h0F0F0F0F, 32'h02040608);
      issue(32'h80000001, 32'hFFFFFFFF, 32'h80000001);
      repeat (3) idle(1'b0);
      repeat (2) idle(1'b1);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = ~ra;
            issue(ra, rb, ra & rb);
         end else begin
            idle($urandom_range(0, 1) == 1);
         end
      end

      // Reset mid-stream while a capture is pending and in_valid stays high.
      issue(32'h80000001, 32'hFFFFFFFF, 32'h80000001);
      @(posedge clk);
      #1;
      check("pre_reset_R", r, 32'h80000001);
      a        = $urandom;
      b        = $urandom;
      in_valid = 1'b1;
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      last_r = '0;
      #1 check_reset_now("mid_reset");
      repeat (2) @(posedge clk);
      #1 check_reset_now("held_reset");
      rst_n    = 1'b1;
      in_valid = 1'b0;
      idle(1'b0);
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom;
         issue(ra, rb, ra & rb);
      end

      // Drain with a bounded wait.
      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 10) begin
         idle(1'b0);
         wait_cnt++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d results still outstanding, required 0", exp_q.size());
      end
      @(negedge clk);
      @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
